// File: rtl/ctrl_sumador_multibyte.sv
// ctrl_sumador_multibyte: shares one 8-bit ripple-carry adder (SUM_RIZADO)
// between two requesters and performs WORDS-byte additions byte-serially,
// LSB byte first, with the inter-byte carry held in a register.
// Optional build macro: CTRL_SUMADOR_SUB_EN adds per-requester op0/op1
// (0=add, 1=sub) inputs and a signed-overflow output ovf.

// SUM_RIZADO: 8-bit adder. The PwrC value selects how it is described to the
// power-characterisation flow: explicit full-adder cells (0) or a behavioural
// sum (non-zero). Both descriptions are functionally identical.
module SUM_RIZADO #(
  parameter int PwrC = 0
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  generate
    if (PwrC == 0) begin : g_cells
      logic [8:0] c;
      assign c[0] = ci;
      for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      assign co = c[8];
    end else begin : g_behav
      assign {co, s} = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    end
  endgenerate

endmodule

module ctrl_sumador_multibyte #(
  parameter int WORDS = 4,
  parameter int PwrC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [8*WORDS-1:0]   a0,
  input  logic [8*WORDS-1:0]   b0,
  input  logic                 req1,
  input  logic [8*WORDS-1:0]   a1,
  input  logic [8*WORDS-1:0]   b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   res,
  output logic                 res_id,
  output logic                 cout
`ifdef CTRL_SUMADOR_SUB_EN
  ,
  input  logic                 op0,
  input  logic                 op1,
  output logic                 ovf
`endif
);

  localparam int N  = 8 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           last_grant;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;

  logic           grant0;
  logic           grant1;
  logic           grant_any;
  logic           init_carry;

  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic [7:0]     add_s;
  logic           add_co;

  // Round-robin arbitration, evaluated only while idle; on a tie the
  // requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign ack0      = grant0;
  assign ack1      = grant1;
  assign grant_any = grant0 | grant1;

  assign add_a = opa[7:0];

`ifdef CTRL_SUMADOR_SUB_EN
  logic sub_q;
  logic sub_sel;

  assign sub_sel    = grant1 ? op1 : op0;
  assign init_carry = sub_sel;
  assign add_b      = sub_q ? ~opb[7:0] : opb[7:0];

  // Remember the operation type of the granted request and flag signed
  // overflow from the sign bits of the final (MSB) byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (grant_any) begin
        sub_q <= sub_sel;
      end
      if (state == RUN && idx == LAST_IDX) begin
        ovf <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
      end
    end
  end
`else
  assign init_carry = 1'b0;
  assign add_b      = opb[7:0];
`endif

  SUM_RIZADO #(
    .PwrC(PwrC)
  ) u_sum (
    .a (add_a),
    .b (add_b),
    .ci(carry),
    .s (add_s),
    .co(add_co)
  );

  // Sequencer: latch operands at grant, feed one byte per cycle through the
  // shared adder, shift sum bytes into res from the top, then pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      opa        <= '0;
      opb        <= '0;
      res        <= '0;
      res_id     <= 1'b0;
      cout       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (grant_any) begin
            opa        <= grant1 ? a1 : a0;
            opb        <= grant1 ? b1 : b0;
            res_id     <= grant1;
            last_grant <= grant1;
            carry      <= init_carry;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 8;
          opb   <= opb >> 8;
          res   <= {add_s, res[N-1:8]};
          carry <= add_co;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= add_co;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ctrl_sumador_multibyte.md
Name: ctrl_sumador_multibyte

Overview:
- Sequencer/arbiter that shares one 8-bit ripple-carry adder instance (`SUM_RIZADO`) between two requesters.
- Performs WORDS×8-bit additions byte-serially, LSB byte first, with the carry registered between bytes.
- Sits between requesting datapath blocks and the power-characterised adder; PwrC is passed through unchanged to the adder instance.

Parameters:
- WORDS, 4, number of bytes per operand (2..8); operand width N = 8*WORDS.
- PwrC, 0, power-characterisation value forwarded to the `SUM_RIZADO` instance.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 operation request; held until ack0.
- a0  in  N  requester 0 operand A.
- b0  in  N  requester 0 operand B.
- req1  in  1  requester 1 operation request; held until ack1.
- a1  in  N  requester 1 operand A.
- b1  in  N  requester 1 operand B.
- ack0  out  1  one-cycle grant/accept pulse for requester 0.
- ack1  out  1  one-cycle grant/accept pulse for requester 1.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse: result valid.
- res  out  N  sum result; holds its value until the next done.
- res_id  out  1  requester that owns res.
- cout  out  1  final carry out of the MSB byte.

Behaviour:
- States: IDLE, RUN, DONE. Byte counter idx is clog2(WORDS) bits wide.
- Reset (async): state=IDLE, idx=0, carry reg=0, res=0, res_id=0, cout=0, done=0, busy=0, last_grant=1. ack0/ack1 are combinational and therefore 0 in reset.
- IDLE:
  - If any req is high, grant by round-robin: with both high, grant the requester other than last_grant; otherwise grant the single requester.
  - ackX is asserted combinationally in that same cycle.
  - At the edge: latch aX/bX into operand shift registers, set res_id=X and last_grant=X, carry=0, idx=0, go to RUN.
- RUN (exactly WORDS cycles):
  - Adder inputs: a=opA[7:0], b=opB[7:0], ci=carry.
  - At each edge: shift operands right 8 bits; shift adder s into the result register from the top; carry<=adder co; idx++.
  - When idx==WORDS-1: cout<=co, go to DONE.
- DONE (1 cycle): done=1; res, res_id and cout are valid; next state IDLE.
  - Requests arriving during RUN/DONE wait; they are evaluated only in IDLE.
- Latency: ack cycle T → done in cycle T+WORDS+1. Back-to-back throughput is one op per WORDS+2 cycles.
- Arithmetic:
  - res = (A+B) mod 2^N; cout = bit N of the sum.
  - Wrap-around (all-ones + 1) gives res=0, cout=1.
- Requester rules:
  - Operands are sampled only in the ack cycle; changes afterwards are ignored.
  - A requester dropping req before ack is legal; nothing is started for it.
- Reset mid-operation: the in-flight op is discarded, no done is produced, and res returns to 0.
- Adder instance: PwrC is passed through. res and res_id are updated only by RUN shifts and at grant; res is stable outside RUN.

Optional Feature:
- Macro CTRL_SUMADOR_SUB_EN.
- When defined:
  - Extra inputs op0 and op1 (1 bit each, 0=add, 1=sub), sampled at ack.
  - Sub drives the adder b input with ~opB[7:0] and initialises carry to 1, giving res=(A-B) mod 2^N; cout=1 means no borrow.
  - Extra output ovf, registered at the RUN→DONE edge: signed overflow of the final MSB (effective-operand signs equal and result sign different), reset 0.
- When undefined: add only; no op0/op1/ovf ports.

Test Plan:
- WORDS=4, req0 only, a0=0x12345678, b0=0x11111111 → ack0 in cycle T, done in cycle T+5, res=0x23456789, res_id=0, cout=0.
- a1=0xFFFFFFFF, b1=0x00000001 → res=0x00000000, cout=1 (carry ripples across all byte boundaries).
- req0 and req1 both held continuously from reset → grants alternate 0,1,0,1; each done carries the matching res_id; no grant occurs during busy.
- rst pulsed during RUN at idx=2 → done never rises, res=0, state IDLE; a new req0 is granted on the first cycle after rst falls.
- req1 rises during DONE → no ack that cycle; ack1 in the following IDLE cycle; requester-0 operands changed after ack0 do not alter its res.
- With CTRL_SUMADOR_SUB_EN: op0=1, a0=0x00000005, b0=0x00000007 → res=0xFFFFFFFE, cout=0, ovf=0. Then a0=0x7FFFFFFF, b0=0xFFFFFFFF, op0=1 → res=0x80000000, ovf=1.
